// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key controller.
package ps2_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

endpackage

// File: rtl/ps2_key_controller_if.sv
// Valid/ready key-event channel from the PS/2 controller to the game logic.
interface ps2_key_controller_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;

  modport master (output evt_valid, evt_code, evt_break, evt_ext, input evt_ready);
  modport slave  (input evt_valid, evt_code, evt_break, evt_ext, output evt_ready);
endinterface

// File: rtl/ps2_key_controller_key_evt_fifo.sv
// First-word-fall-through queue of key events; push and pop may coincide even when full.
module key_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  key_evt_t din,
  input  logic     ready,
  output logic     valid,
  output key_evt_t dout,
  output logic     overflow
);
  localparam int AW = $clog2(DEPTH);

  key_evt_t          mem [DEPTH];
  logic [AW-1:0]     rptr, wptr;
  logic [AW:0]       cnt;
  logic              full, pop, wr;

  assign valid    = (cnt != '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign pop      = valid && ready;
  assign wr       = push && (!full || pop);
  assign overflow = push && full && !pop;
  assign dout     = mem[rptr];

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr)  wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/ps2_key_controller.sv
// PS/2 keyboard receiver: sync, 11-bit frame FSM, E0/F0 prefix folding, event queue.
// Define KEYEVT_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single holding register.
module ps2_key_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  ps2_key_controller_if.master        evt,
  output logic                        frame_err,
  output logic                        overflow
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]  clk_sync, data_sync;
  logic        clk_prev, fall, data_s;
  ps2_state_t  state, state_n;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        par_bit;
  logic [CW-1:0] to_cnt;
  logic        stop_ok, stop_bad, tmo;
  logic        byte_vld;
  logic        ext_pend, brk_pend;
  logic        push, pop, valid;
  key_evt_t    evt_in, head;

  assign data_s = data_sync[1];
  assign fall   = clk_prev && !clk_sync[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      clk_prev  <= clk_sync[1];
    end
  end

  always_comb begin
    state_n  = state;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    tmo      = 1'b0;
    if (fall) begin
      case (state)
        IDLE:    if (!data_s) state_n = DATA;
        DATA:    if (bit_cnt == 3'd7) state_n = PARITY;
        PARITY:  state_n = STOP;
        STOP: begin
          state_n = IDLE;
          if (data_s && ^{shreg, par_bit}) stop_ok  = 1'b1;
          else                             stop_bad = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end else if (state != IDLE && to_cnt == CW'(TIMEOUT_CYC - 1)) begin
      state_n = IDLE;
      tmo     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      byte_vld  <= stop_ok;
      frame_err <= stop_bad || tmo;
      if (fall || state == IDLE || tmo) to_cnt <= '0;
      else                              to_cnt <= to_cnt + 1'b1;
      if (fall && state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && state == PARITY) par_bit <= data_s;
    end
  end

  // shreg is untouched until the next frame's first data edge, so it is still valid here
  assign push   = byte_vld && shreg != PS2_EXT_PREFIX && shreg != PS2_BREAK_PREFIX;
  assign evt_in = '{ext: ext_pend, brk: brk_pend, code: shreg};

  always_ff @(posedge clk) begin
    if (rst || frame_err) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else if (byte_vld) begin
      if (shreg == PS2_EXT_PREFIX)        ext_pend <= 1'b1;
      else if (shreg == PS2_BREAK_PREFIX) brk_pend <= 1'b1;
      else begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end
    end
  end

`ifdef KEYEVT_FIFO_EN
  assign pop = valid && evt.evt_ready;

  key_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .din      (evt_in),
    .ready    (evt.evt_ready),
    .valid    (valid),
    .dout     (head),
    .overflow (overflow)
  );
`else
  assign pop      = valid && evt.evt_ready;
  assign overflow = push && valid && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (push && (!valid || pop)) begin
      valid <= 1'b1;
      head  <= evt_in;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end
`endif

  assign evt.evt_valid = valid;
  assign evt.evt_code  = head.code;
  assign evt.evt_break = head.brk;
  assign evt.evt_ext   = head.ext;
endmodule

// File: doc/ps2_key_controller.md
# ps2_key_controller

Sequences PS/2 keyboard frame reception and turns raw scancode bytes into key events for the game logic. It oversamples the keyboard clock and data lines in the system clock domain and runs the 11-bit frame state machine with parity, stop-bit and timeout checks. It folds E0 (extended) and F0 (break) prefixes into a single event and delivers events through a valid/ready queue. It sits between the PS/2 pins and the game controller / seven-segment display logic.

## Interface
- TIMEOUT_CYC, 50000, system cycles without a PS/2 falling edge before an in-progress frame is abandoned (1 ms at 50 MHz)
- FIFO_DEPTH, 4, event queue depth (power of two, ≥2); used only when the FIFO is compiled in
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- ps2_clk  in  1  raw keyboard clock, asynchronous
- ps2_data  in  1  raw keyboard data, asynchronous
- evt_valid  out  1  head event available
- evt_ready  in  1  consumer accepts head event
- evt_code  out  8  scancode byte of head event
- evt_break  out  1  head event is a key release (F0 seen)
- evt_ext  out  1  head event is extended (E0 seen)
- frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error
- overflow  out  1  one-cycle pulse when an event is dropped because the queue is full

## Operation
- Synchronizers: 2-FF sync on ps2_clk and ps2_data, both reset to 1. Falling edge = previous synced clock 1 and current synced clock 0. All sampling uses synced data on that cycle.
- Frame FSM states:
  - IDLE: on an edge with data 0 (start bit), go to DATA with bit count 0. On an edge with data 1, stay in IDLE with no error.
  - DATA: shift in 8 bits LSB first, one per edge. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: the byte is accepted if the stop bit is 1 and the 8 data bits plus the parity bit contain an odd number of ones. Otherwise frame_err pulses. Return to IDLE in either case.
- Timeout counter: clears on every edge and counts while the FSM is not in IDLE. On reaching TIMEOUT_CYC-1, frame_err pulses, the FSM goes to IDLE and the partial byte is discarded.
- Prefix decode of accepted bytes:
  - 8'hE0 sets ext_pend and emits nothing.
  - 8'hF0 sets brk_pend and emits nothing.
  - Any other byte (including E1) pushes the event {ext_pend, brk_pend, code} and clears both flags.
  - Any frame error clears both flags.
- Queue: first-word-fall-through.
  - A pop occurs when evt_valid and evt_ready are both high.
  - Head outputs stay stable while evt_valid is high and no pop occurs. They are don't-care while evt_valid is low.
  - A push when the queue is full and there is no simultaneous pop drops the new event and pulses overflow. Queue contents are unchanged.
  - A push and a pop in the same cycle both succeed, including when the queue is full.
  - Events leave in arrival order.
- Reset values: FSM IDLE, all counters 0, ext_pend and brk_pend 0, queue empty, evt_valid 0, frame_err 0, overflow 0.
- Reset mid-frame: the partial frame is lost. Resynchronization relies on the start-bit, parity, stop and timeout checks.

## Timing
- Synchronizer latency: 2 cycles from a pin edge to the synced value.
- An edge is detected in cycle N on the synced signals. A byte completed at the stop edge in cycle N is classified in N+1, pushed at the end of N+1, and evt_valid is high in N+2.
- frame_err pulses in cycle N+1 for a parity or stop error detected at edge N. A timeout pulses in the cycle after the counter reaches TIMEOUT_CYC-1.
- overflow pulses in the same cycle as the rejected push.
- After a pop, the next entry is presented in the following cycle. With an empty queue, evt_valid drops in the following cycle.

## Configuration
- KEYEVT_FIFO_EN defined: FIFO_DEPTH-entry queue as described above.
- KEYEVT_FIFO_EN undefined: the queue is a single holding register with the same handshake and push/pop rules.
  - A push while the register is occupied and not popped in the same cycle drops the event and pulses overflow.
  - FIFO_DEPTH is ignored.

## Structure
- Package ps2_pkg contains:
  - enum ps2_state_t {IDLE, DATA, PARITY, STOP}
  - constants PS2_EXT_PREFIX = 8'hE0 and PS2_BREAK_PREFIX = 8'hF0
  - packed struct key_evt_t {ext, brk, code[7:0]}
- One sub-module, key_evt_fifo: a parameterized key_evt_t FIFO, instantiated under KEYEVT_FIFO_EN.

## Test plan
- Frame with byte 8'h1C, parity 0, stop 1, evt_ready=1 -> one event: code 1C, brk 0, ext 0; frame_err stays 0.
- Frames F0 then 1C -> exactly one event: code 1C, brk 1, ext 0.
- Frames E0, F0, 75 -> exactly one event: code 75, brk 1, ext 1; both pending flags clear afterward.
- Byte 8'h16 sent with parity 1 -> frame_err pulses once and no event is produced; a following good 8'h1E frame -> event with code 1E.
- Clock stops after 4 data bits for TIMEOUT_CYC cycles -> frame_err pulses and the FSM is in IDLE; the next frame 8'h45 decodes correctly.
- evt_ready=0 and 5 make codes 16, 1E, 26, 25, 2E sent with FIFO_DEPTH=4 -> overflow pulses on the 5th byte; draining yields 16, 1E, 26, 25 in order.
